// File: rtl/min_prio_arbiter.sv
// rtl/min_prio_arbiter.sv - four-requester lowest-priority-value arbiter with round-robin ties and hold watchdog
module min_prio_arbiter #(
  parameter int PRIO_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [3:0]            req,
  input  logic [4*PRIO_W-1:0]   prio,
  input  logic                  done,
  output logic [3:0]            gnt,
  output logic [1:0]            gnt_id,
  output logic [PRIO_W-1:0]     gnt_prio,
  output logic                  gnt_valid,
  output logic                  timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [1:0]          rr_ptr;

  logic [1:0]          win_id;
  logic [PRIO_W-1:0]   win_prio;
  logic                win_found;
  logic [1:0]          scan_idx;

  // Scan starting just after the last winner; strict '<' keeps the first tie seen.
  always_comb begin
    win_id    = '0;
    win_prio  = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (req[scan_idx] &&
          (!win_found || (prio[scan_idx*PRIO_W +: PRIO_W] < win_prio))) begin
        win_found = 1'b1;
        win_id    = scan_idx;
        win_prio  = prio[scan_idx*PRIO_W +: PRIO_W];
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_prio  <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= 2'd3;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            gnt       <= 4'b0001 << win_id;
            gnt_id    <= win_id;
            gnt_prio  <= win_prio;
            gnt_valid <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
            rr_ptr    <= win_id;
          end
        end
        BUSY: begin
          // done / request drop take precedence over the watchdog
          if (done || !req[gnt_id]) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            timeout   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_min_prio_arbiter.sv
// tb/tb_min_prio_arbiter.sv - bench for min_prio_arbiter against a reference model
module tb_min_prio_arbiter;

  localparam int PRIO_W   = 8;
  localparam int MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] prio = '0;
  logic        done = 1'b0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  gnt_prio;
  logic        gnt_valid;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  min_prio_arbiter #(.PRIO_W(PRIO_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .areset(areset), .req(req), .prio(prio), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_prio(gnt_prio),
    .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lowest value among active requesters, ties to first index after last winner.
  function automatic int pick(input logic [3:0] r, input logic [31:0] p, input int rr);
    int mn = 256;
    for (int i = 0; i < 4; i++)
      if (r[i] && int'(p[i*8 +: 8]) < mn) mn = int'(p[i*8 +: 8]);
    for (int k = 1; k <= 4; k++) begin
      int idx = (rr + k) % 4;
      if (r[idx] && int'(p[idx*8 +: 8]) == mn) return idx;
    end
    return 0;
  endfunction

  bit m_valid;
  int m_id, m_prio, m_hold, m_rr;
  bit m_timeout;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_valid <= 0; m_id <= 0; m_prio <= 0; m_hold <= 0; m_rr <= 3; m_timeout <= 0;
    end else begin
      m_timeout <= 0;
      if (!m_valid) begin
        if (req != 0) begin
          int w;
          w = pick(req, prio, m_rr);
          m_valid <= 1; m_id <= w; m_prio <= int'(prio[w*8 +: 8]); m_hold <= 1; m_rr <= w;
        end
      end else if (done || !req[m_id]) begin
        m_valid <= 0; m_hold <= 0;
      end else if (m_hold == MAX_HOLD) begin
        m_valid <= 0; m_hold <= 0; m_timeout <= 1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_gnt", 32'(gnt), m_valid ? 32'(1 << m_id) : 32'd0);
    check("model_gnt_valid", 32'(gnt_valid), 32'(m_valid));
    check("model_timeout", 32'(timeout), 32'(m_timeout));
    if (m_valid) begin
      check("model_gnt_id", 32'(gnt_id), 32'(m_id));
      check("model_gnt_prio", 32'(gnt_prio), 32'(m_prio));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 areset = 1'b1;
    tick(1);
    areset = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_gnt_id", 32'(gnt_id), 0);
    check("rst_gnt_prio", 32'(gnt_prio), 0);
    check("rst_gnt_valid", 32'(gnt_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    tick(2);
    areset = 1'b0;
    tick(1);

    // single request then done
    req = 4'b0100; prio = {8'h00, 8'h30, 8'h00, 8'h00};
    tick(1);
    check("s1_gnt", 32'(gnt), 32'b0100);
    check("s1_gnt_id", 32'(gnt_id), 2);
    check("s1_gnt_prio", 32'(gnt_prio), 32'h30);
    done = 1'b1;
    tick(1);
    done = 1'b0; req = 4'b0000;
    check("s1_release", 32'(gnt), 0);
    tick(1);

    // minimum select with round-robin tie
    do_reset();
    req = 4'b1111; prio = {8'h10, 8'h05, 8'h80, 8'h05};
    tick(1);
    check("s2_first", 32'(gnt_id), 0);
    done = 1'b1; tick(1); done = 1'b0;
    check("s2_gap", 32'(gnt_valid), 0);
    tick(1);
    check("s2_tie_rr", 32'(gnt_id), 2);
    done = 1'b1; req = 4'b1010; tick(1); done = 1'b0;
    tick(1);
    check("s2_next", 32'(gnt_id), 3);
    done = 1'b1; req = 4'b0000; tick(1); done = 1'b0;
    tick(1);

    // idle requesters ignored even with lower value
    req = 4'b1010; prio = {8'h20, 8'h00, 8'h40, 8'h00};
    tick(1);
    check("s3_gnt_id", 32'(gnt_id), 3);
    check("s3_gnt_prio", 32'(gnt_prio), 32'h20);
    req = 4'b0000; tick(2);

    // watchdog release and regrant after one idle cycle
    req = 4'b0001; prio = {8'h00, 8'h00, 8'h00, 8'h11};
    tick(1);
    n = 0;
    while (gnt_valid && n < 40) begin
      n++;
      tick(1);
    end
    check("s4_hold_cycles", 32'(n), 16);
    check("s4_timeout_pulse", 32'(timeout), 1);
    check("s4_gap", 32'(gnt_valid), 0);
    tick(1);
    check("s4_regrant", 32'(gnt), 32'b0001);
    check("s4_timeout_clr", 32'(timeout), 0);
    req = 4'b0000; tick(2);

    // owner drops request; stray done while idle
    req = 4'b0010;
    tick(3);
    req = 4'b0000;
    tick(1);
    check("s5_drop", 32'(gnt_valid), 0);
    check("s5_no_timeout", 32'(timeout), 0);
    done = 1'b1;
    tick(2);
    check("s5_idle_done", 32'(gnt_valid), 0);
    req = 4'b0001;
    tick(1);
    done = 1'b0;
    check("s5_grant_despite_done", 32'(gnt), 32'b0001);
    req = 4'b0000; tick(2);

    // mixed traffic exercising ties and random releases
    for (int i = 0; i < 60; i++) begin
      req  = 4'($urandom);
      prio = {(($urandom % 2) != 0) ? 8'h20 : 8'h10, (($urandom % 2) != 0) ? 8'h20 : 8'h10,
              (($urandom % 2) != 0) ? 8'h20 : 8'h10, (($urandom % 2) != 0) ? 8'h20 : 8'h10};
      done = ($urandom % 4) == 0;
      tick(1);
    end
    req = 4'b0000; done = 1'b0; tick(2);

    // asynchronous reset mid-grant, then tie restarts at requester 0
    req = 4'b0011; prio = {8'h00, 8'h00, 8'h07, 8'h07};
    tick(2);
    #1 areset = 1'b1;
    #1;
    check("s6_async_gnt", 32'(gnt), 0);
    check("s6_async_valid", 32'(gnt_valid), 0);
    check("s6_async_timeout", 32'(timeout), 0);
    tick(1);
    areset = 1'b0;
    tick(1);
    check("s6_tie_after_rst", 32'(gnt_id), 0);
    req = 4'b0000; tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
